// File: rtl/hamming_tx_ctrl.sv
// Hamming(7,4) serial transmit controller: buffers 4-bit messages in a small
// FIFO, encodes each into a 7-bit codeword and shifts it out code[1] first.
module hamming_tx_ctrl #(
  parameter int DEPTH      = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:4]               msg_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     tx_en,
  output logic                     tx_bit,
  output logic                     tx_frame,
  output logic                     frame_done,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Parity positions 1, 2 and 4 each cover the data positions whose index has that bit set.
  function automatic logic [1:7] hamming_enc(input logic [1:4] m);
    logic [1:7] c;
    c    = 7'b0000000;
    c[3] = m[1];
    c[5] = m[2];
    c[6] = m[3];
    c[7] = m[4];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  logic [1:4]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  state_t        state_r;
  logic [1:7]    code_r;
  logic [2:0]    idx_r;
  logic [GW-1:0] gap_cnt_r;
  logic          tx_bit_r;
  logic          tx_frame_r;
  logic          frame_done_r;

  logic          push_s;
  logic          pop_s;
  logic          in_ready_s;

  // Handshake qualifiers for the FIFO; a pop is the IDLE load of the next frame.
  always_comb begin
    in_ready_s = 1'b0;
    push_s     = 1'b0;
    pop_s      = 1'b0;
    if (count_r < (AW + 1)'(DEPTH)) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
    push_s = in_valid && in_ready_s;
    if ((state_r == IDLE) && (count_r != (AW + 1)'(0))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Message FIFO storage, pointers (wrapping naturally at DEPTH) and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= (AW + 1)'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 4'b0000;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= msg_in;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer: load, shift seven bits under tx_en, then the inter-frame gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      code_r       <= 7'b0000000;
      idx_r        <= 3'd1;
      gap_cnt_r    <= GW'(0);
      tx_bit_r     <= 1'b0;
      tx_frame_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tx_bit_r     <= 1'b0;
          tx_frame_r   <= 1'b0;
          frame_done_r <= 1'b0;
          if (pop_s) begin
            code_r  <= hamming_enc(mem_r[rd_ptr_r]);
            idx_r   <= 3'd1;
            state_r <= SHIFT;
          end
        end
        SHIFT: begin
          tx_frame_r   <= 1'b1;
          tx_bit_r     <= code_r[idx_r];
          frame_done_r <= 1'b0;
          // A disabled cycle re-drives the same bit without advancing.
          if (tx_en) begin
            if (idx_r == 3'd7) begin
              frame_done_r <= 1'b1;
              idx_r        <= 3'd1;
              if (GAP_CYCLES == 0) begin
                state_r <= IDLE;
              end else begin
                gap_cnt_r <= GW'(GAP_CYCLES);
                state_r   <= GAP;
              end
            end else begin
              idx_r <= idx_r + 3'd1;
            end
          end
        end
        GAP: begin
          tx_bit_r     <= 1'b0;
          tx_frame_r   <= 1'b0;
          frame_done_r <= 1'b0;
          if (tx_en) begin
            if (gap_cnt_r <= GW'(1)) begin
              state_r <= IDLE;
            end else begin
              gap_cnt_r <= gap_cnt_r - GW'(1);
            end
          end
        end
        default: begin
          state_r      <= IDLE;
          tx_bit_r     <= 1'b0;
          tx_frame_r   <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_s;
  assign fifo_count = count_r;
  assign busy       = (state_r != IDLE) || (count_r != (AW + 1)'(0));
  assign tx_bit     = tx_bit_r;
  assign tx_frame   = tx_frame_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_hamming_tx_ctrl.sv
// Scoreboard bench for hamming_tx_ctrl: stimulus queues expected frames, a
// negedge monitor reassembles serial frames and checks them in order.
module tb_hamming_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:4] msg_in = 4'b0000;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx_en = 1'b1;
  logic       tx_bit;
  logic       tx_frame;
  logic       frame_done;
  logic [1:0] fifo_count;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:4] msg;
    logic [1:7] code;
    bit         has_code;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;

  hamming_tx_ctrl #(.DEPTH(2), .GAP_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_in     (msg_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_en      (tx_en),
    .tx_bit     (tx_bit),
    .tx_frame   (tx_frame),
    .frame_done (frame_done),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a bit is final when the edge that drove it had tx_en=1.
  logic       en_q = 1'b1;
  int         cyc = 0;
  int         nb = 0;
  int         frames_started = 0;
  int         gap_idx = -1;
  int         last_end = 0;
  int         fd_count = 0;
  logic [1:7] rx = 7'b0000000;
  logic [2:0] syn;

  always @(posedge clk) en_q <= tx_en;

  always @(negedge clk) begin
    cyc++;
    if (frame_done === 1'b1) fd_count++;
    if (rst) begin
      nb = 0;
    end else if (tx_frame === 1'b1 && en_q) begin
      if (nb == 0) begin
        if (frames_started == gap_idx) chk("frame_gap", cyc - last_end, 3);
        frames_started++;
      end
      nb++;
      rx[nb] = tx_bit;
      chk("frame_done_pos", {31'd0, frame_done}, {31'd0, (nb == 7)});
      if (nb == 7) begin
        last_end = cyc;
        nb = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          e_m = exp_q.pop_front();
          syn = {rx[4] ^ rx[5] ^ rx[6] ^ rx[7],
                 rx[2] ^ rx[3] ^ rx[6] ^ rx[7],
                 rx[1] ^ rx[3] ^ rx[5] ^ rx[7]};
          chk("syndrome", {29'd0, syn}, 0);
          chk("data_bits", {28'd0, rx[3], rx[5], rx[6], rx[7]}, {28'd0, e_m.msg});
          if (e_m.has_code) chk("codeword", {25'd0, rx}, {25'd0, e_m.code});
        end
      end
    end else if (tx_frame === 1'b1) begin
      chk("frame_done_hold", {31'd0, frame_done}, 0);
    end else if (frame_done !== 1'b0) begin
      chk("frame_done_idle", {31'd0, frame_done}, 0);
    end
  end

  task automatic push(input logic [1:4] m, input logic [1:7] c, input bit hc);
    msg_in   = m;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        exp_q.push_back('{m, c, hc});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("push_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && busy === 1'b0) return;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", 0, 1);
  endtask

  int fd0;
  int stray;

  initial begin
    rst   = 1'b1;
    tx_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_tx_frame", {31'd0, tx_frame}, 0);
    chk("rst_tx_bit", {31'd0, tx_bit}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_fifo_count", {30'd0, fifo_count}, 0);

    // Single frame 1011 -> 0110011, with load/first-bit latency.
    push(4'b1011, 7'b0110011, 1'b1);
    chk("lat_count_t1", {30'd0, fifo_count}, 1);
    @(posedge clk); #1;
    chk("lat_frame_t1", {31'd0, tx_frame}, 0);
    chk("lat_pop_t1", {30'd0, fifo_count}, 0);
    chk("lat_busy_t1", {31'd0, busy}, 1);
    @(posedge clk); #1;
    chk("lat_frame_t2", {31'd0, tx_frame}, 1);
    chk("lat_bit1_t2", {31'd0, tx_bit}, 0);
    wait_drain();

    // Back-to-back frames with the gap measured by the monitor.
    gap_idx = 2;
    push(4'b0000, 7'b0000000, 1'b1);
    push(4'b1111, 7'b1111111, 1'b1);
    wait_drain();

    // Stalled line: FIFO fills, fourth push is held off.
    tx_en = 1'b0;
    push(4'b0101, 7'b0100101, 1'b1);
    push(4'b0011, 7'b1000011, 1'b1);
    push(4'b1100, 7'b0111100, 1'b1);
    msg_in   = 4'b0110;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("full_in_ready", {31'd0, in_ready}, 0);
      chk("full_count", {30'd0, fifo_count}, 2);
      chk("stall_frame", {31'd0, tx_frame}, 1);
      chk("stall_bit1", {31'd0, tx_bit}, 0);
      @(posedge clk); #1;
    end
    tx_en = 1'b1;
    push(4'b0110, 7'b1100110, 1'b1);
    wait_drain();

    // Stall three cycles on bit 4 of 1000 -> 1110000.
    fd0 = fd_count;
    push(4'b1000, 7'b1110000, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_frame", {31'd0, tx_frame}, 1);
      chk("hold_bit4", {31'd0, tx_bit}, 0);
    end
    tx_en = 1'b1;
    wait_drain();
    chk("frame_done_once", fd_count - fd0, 1);

    // Reset during bit 5 with one message still queued.
    push(4'b0101, 7'b0100101, 1'b1);
    push(4'b0011, 7'b1000011, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_frame", {31'd0, tx_frame}, 1);
    chk("pre_rst_bit5", {31'd0, tx_bit}, 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_frame", {31'd0, tx_frame}, 0);
    chk("abort_count", {30'd0, fifo_count}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (tx_frame !== 1'b0) stray++;
    end
    chk("abort_no_bits", stray, 0);

    // All sixteen messages, checked by syndrome and data recovery.
    for (int m = 0; m < 16; m++) begin
      push(4'(m), 7'b0000000, 1'b0);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
